// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and lane helper for the MEM-stage load/store unit.
// Lanes are big-endian: byte offset 0 lives in bits [31:24].
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } lsu_req_t;

  // Right shift (in bits) that brings the addressed lane down to bit 0.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset, input logic [1:0] size);
    logic [4:0] sh;
    sh = 5'd0;
    case (size)
      SZ_BYTE: sh = {~offset, 3'b000};
      SZ_HALF: sh = {~offset[1], 4'b0000};
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load lane and merges a store lane
// into a read word. Used by both the LOAD and the read-modify-write read cycle.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shift;
  logic [31:0] lane;
  logic [31:0] wdata_shifted;
  logic [3:0]  byte_en;
  logic        sign;

  assign shift         = lane_shift(offset, size);
  assign lane          = word >> shift;
  assign wdata_shifted = wdata << shift;

  always_comb begin
    sign      = 1'b0;
    load_data = lane;
    case (size)
      SZ_BYTE: begin
        sign      = ~is_unsigned & lane[7];
        load_data = {{24{sign}}, lane[7:0]};
      end
      SZ_HALF: begin
        sign      = ~is_unsigned & lane[15];
        load_data = {{16{sign}}, lane[15:0]};
      end
      default: load_data = lane;
    endcase
  end

  // shift[4:3] is the physical byte lane index of the lowest lane touched.
  always_comb begin
    byte_en = 4'b1111;
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << shift[4:3];
      SZ_HALF: byte_en = 4'b0011 << shift[4:3];
      default: byte_en = 4'b1111;
    endcase
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = byte_en[gi] ? wdata_shifted[8*gi +: 8] : word[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns byte-addressed LB/LH/LW/SB/SH/SW requests into
// word accesses on a single-port data memory, with sub-word stores done as RMW.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(4 * MEM_DEPTH);

  lsu_state_e        state_reg, state_next;
  lsu_req_t          req_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       merge_reg;
  logic [31:0]       rsp_rdata_reg;
  logic              rsp_err_reg;
  logic              req_err;
  logic              accept;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign accept = req_valid && (state_reg == IDLE);

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      SZ_ILL:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= BYTE_LIMIT) req_err = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                  state_next = RESP;
          else if (!req_store)          state_next = LOAD;
          else if (req_size == SZ_WORD) state_next = WRITE;
          else                          state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_lane_align u_lane_align (
    .word        (mem_rdata),
    .offset      (addr_reg[1:0]),
    .size        (req_reg.size),
    .is_unsigned (req_reg.is_unsigned),
    .wdata       (req_reg.wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_reg       <= '0;
      addr_reg      <= '0;
      merge_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        req_reg.store       <= req_store;
        req_reg.size        <= req_size;
        req_reg.is_unsigned <= req_unsigned;
        req_reg.wdata       <= req_wdata;
        addr_reg            <= req_addr;
        // Rejected requests go straight to RESP, so their response is set here.
        if (req_err) begin
          rsp_rdata_reg <= '0;
          rsp_err_reg   <= 1'b1;
        end
      end
      if (state_reg == LOAD) begin
        rsp_rdata_reg <= load_data;
        rsp_err_reg   <= 1'b0;
      end
      if (state_reg == RMW_RD) merge_reg <= merged;
      if (state_reg == WRITE) begin
        rsp_rdata_reg <= '0;
        rsp_err_reg   <= 1'b0;
      end
    end
  end

  // Memory strobes decode from state alone so an asynchronous reset kills them at once.
  assign mem_read  = (state_reg == LOAD) || (state_reg == RMW_RD);
  assign mem_write = (state_reg == WRITE);
  assign mem_addr  = (state_reg == IDLE) ? '0 : {2'b00, addr_reg[ADDR_W-1:2]};
  assign mem_wdata = (state_reg != WRITE) ? 32'h0 :
                     (req_reg.size == SZ_WORD) ? req_reg.wdata : merge_reg;

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory and a transaction-level
// reference model compared against the DUT outputs every cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.MEM_DEPTH(256), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Data memory plus a preload port shared with the reference model.
  logic [31:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  assign mem_rdata = (mem_read && mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write && mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // kind: 0 rejected, 1 load, 2 whole-word store, 3 sub-word store
  function automatic int kind_of(input logic st, input logic [1:0] sz, input logic [31:0] ad);
    bit bad;
    bad = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00) ||
          (ad >= 32'd1024);
    if (bad) return 0;
    if (!st) return 1;
    if (sz == 2'b10) return 2;
    return 3;
  endfunction

  function automatic int len_of(input int k);
    if (k == 0) return 1;
    if (k == 3) return 3;
    return 2;
  endfunction

  function automatic int wphase(input int k);
    if (k == 2) return 1;
    if (k == 3) return 2;
    return 99;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic un);
    logic [7:0]  b [4];
    logic [31:0] v;
    int o;
    o = int'(off);
    for (int i = 0; i < 4; i++) b[i] = 8'(w >> (24 - 8 * i));
    if (sz == 2'b00) begin
      v = {24'h0, b[o]};
      if (!un && b[o][7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'h0, b[o], b[o+1]};
      if (!un && b[o][7]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge_val(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [7:0] b [4];
    int o;
    o = int'(off);
    for (int i = 0; i < 4; i++) b[i] = 8'(w >> (24 - 8 * i));
    if (sz == 2'b00) begin
      b[o] = d[7:0];
    end else if (sz == 2'b01) begin
      b[o]   = d[15:8];
      b[o+1] = d[7:0];
    end else begin
      return d;
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  logic [31:0] ref_mem [256];
  int          m_len, m_phase, m_kind;
  logic [31:0] m_waddr, m_rdata, m_wdata, m_hold_rdata;
  logic        m_err, m_hold_err;
  int          acc_kind;
  logic [31:0] acc_word;

  always_comb begin
    acc_kind = kind_of(req_store, req_size, req_addr);
    acc_word = ref_mem[req_addr[9:2]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_len <= 0; m_phase <= 0; m_kind <= 0;
      m_waddr <= '0; m_rdata <= '0; m_wdata <= '0; m_err <= 1'b0;
      m_hold_rdata <= '0; m_hold_err <= 1'b0;
    end else begin
      if (pl_en) ref_mem[pl_addr] <= pl_data;
      if (m_len == 0) begin
        if (req_valid) begin
          m_kind  <= acc_kind;
          m_len   <= len_of(acc_kind);
          m_phase <= 1;
          m_waddr <= req_addr >> 2;
          m_err   <= (acc_kind == 0);
          m_rdata <= (acc_kind == 1) ? load_val(acc_word, req_addr[1:0], req_size, req_unsigned) : 32'h0;
          m_wdata <= merge_val(acc_word, req_addr[1:0], req_size, req_wdata);
        end
      end else if (m_phase == m_len) begin
        m_len        <= 0;
        m_hold_rdata <= m_rdata;
        m_hold_err   <= m_err;
      end else begin
        if (m_phase == wphase(m_kind)) ref_mem[m_waddr[7:0]] <= m_wdata;
        m_phase <= m_phase + 1;
      end
    end
  end

  logic        e_ready, e_rsp, e_rd, e_wr, e_err;
  logic [31:0] e_addr, e_rdata;

  always_comb begin
    e_ready = (m_len == 0);
    e_rsp   = (m_len != 0) && (m_phase == m_len);
    e_rd    = (m_len != 0) && (m_phase == 1) && (m_kind == 1 || m_kind == 3);
    e_wr    = (m_len != 0) && (m_phase == wphase(m_kind));
    e_addr  = (m_len != 0) ? m_waddr : 32'h0;
    e_rdata = e_rsp ? m_rdata : m_hold_rdata;
    e_err   = e_rsp ? m_err : m_hold_err;
  end

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("mem_read", 32'(mem_read), 32'(e_rd));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("mem_addr", mem_addr, e_addr);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    if (e_wr) chk("mem_wdata", mem_wdata, m_wdata);
  end

  // ---------------- stimulus ----------------
  task automatic preload(input int a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = 8'(a); pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic hold, input logic [31:0] next_ad,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [7:0] rs, output logic [7:0] ws,
                        output int acc_c, output int rsp_c);
    int n;
    rd = '0; er = 1'b0; lat = 0; rs = '0; ws = '0; acc_c = 0; rsp_c = 0;
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = ad; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_c = cyc;
    if (hold) req_addr = next_ad;
    else req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rs[k-1] = mem_read;
      ws[k-1] = mem_write;
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; rsp_c = cyc;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++; n_bad++;
      $display("FAIL rsp_timeout: no rsp_valid within 8 cycles, expected one");
    end else begin
      @(negedge clk);
      chk("rsp_pulse", 32'(rsp_valid), 32'h0);
    end
    $display("txn st=%0d sz=%0d un=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             st, sz, un, ad, wd, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, ac, rc, ac2, rc2;
  logic [7:0]  rs, ws;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic [31:0] ad;
  } err_vec_t;
  err_vec_t err_tab [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: byte loads, signed and unsigned
    preload(5, 32'h8899_AABB);
    do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 1'b0, 32'h0, rd, er, lat, rs, ws, ac, rc);
    chk("lb_data", rd, 32'hFFFF_FF99);
    chk("lb_err", 32'(er), 32'h0);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_rdseq", 32'(rs), 32'h01);
    do_req(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 1'b0, 32'h0, rd, er, lat, rs, ws, ac, rc);
    chk("lbu_data", rd, 32'h0000_0099);

    // 2: halfword store via read-modify-write
    preload(5, 32'h1122_3344);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, 1'b0, 32'h0, rd, er, lat, rs, ws, ac, rc);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_rdseq", 32'(rs), 32'h01);
    chk("sh_wrseq", 32'(ws), 32'h02);
    chk("sh_rdata", rd, 32'h0);
    chk("sh_mem5", mem[5], 32'h1122_BEEF);

    // 3: word store then halfword loads
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF, 1'b0, 32'h0, rd, er, lat, rs, ws, ac, rc);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wrseq", 32'(ws), 32'h01);
    chk("sw_rdseq", 32'(rs), 32'h00);
    chk("sw_mem5", mem[5], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, rd, er, lat, rs, ws, ac, rc);
    chk("lh_data", rd, 32'hFFFF_DEAD);
    do_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 1'b0, 32'h0, rd, er, lat, rs, ws, ac, rc);
    chk("lhu_data", rd, 32'h0000_DEAD);

    // 4: rejected requests never touch memory
    preload(4, 32'h0102_0304);
    err_tab[0] = '{st: 1'b0, sz: 2'b10, ad: 32'h16};
    err_tab[1] = '{st: 1'b1, sz: 2'b01, ad: 32'h13};
    err_tab[2] = '{st: 1'b0, sz: 2'b11, ad: 32'h14};
    err_tab[3] = '{st: 1'b0, sz: 2'b00, ad: 32'h400};
    for (int i = 0; i < 4; i++) begin
      do_req(err_tab[i].st, err_tab[i].sz, 1'b0, err_tab[i].ad, 32'h5555_AAAA, 1'b0, 32'h0,
             rd, er, lat, rs, ws, ac, rc);
      chk("err_flag", 32'(er), 32'h1);
      chk("err_lat", 32'(lat), 32'd1);
      chk("err_rdata", rd, 32'h0);
      chk("err_memops", {24'h0, rs | ws}, 32'h0);
    end
    chk("err_mem5", mem[5], 32'hDEAD_BEEF);
    chk("err_mem4", mem[4], 32'h0102_0304);

    // 5: reset during the write cycle of a byte store
    preload(5, 32'h1122_3344);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_rmw_rd", 32'(mem_read), 32'h1);
    @(negedge clk);
    chk("rst_mid_write", 32'(mem_write), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_write_drop", 32'(mem_write), 32'h0);
    chk("rst_mid_ready", 32'(req_ready), 32'h1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_mid_mem5", mem[5], 32'h1122_3344);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, rd, er, lat, rs, ws, ac, rc);
    chk("rst_mid_lw", rd, 32'h1122_3344);

    // 6: back-to-back loads with req_valid held high
    preload(0, 32'hCAFE_F00D);
    preload(255, 32'h0BAD_C0DE);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3FC, rd, er, lat, rs, ws, ac, rc);
    chk("b2b_first", rd, 32'hCAFE_F00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0, rd, er, lat, rs, ws, ac2, rc2);
    chk("b2b_second", rd, 32'h0BAD_C0DE);
    chk("b2b_second_err", 32'(er), 32'h0);
    chk("b2b_gap", 32'(ac2 - rc), 32'd2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
